// File: rtl/serial_pixel_comparator_if.sv
// Pixel-pair handshake bundle for the serial comparator.
// slave: comparator side; master: fetch/sort side.
interface serial_pixel_comparator_if #(
  parameter int PIX_W = 8
) ();
  localparam int SW = $clog2(PIX_W/2) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] x_pix;
  logic [PIX_W-1:0] y_pix;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [PIX_W-1:0] max_pix;
  logic [PIX_W-1:0] min_pix;
  logic [SW-1:0]    slices;

  modport slave (
    input  in_valid, x_pix, y_pix, out_ready,
    output in_ready, out_valid, gt, lt, eq,
    output max_pix, min_pix, slices
  );

  modport master (
    output in_valid, x_pix, y_pix, out_ready,
    input  in_ready, out_valid, gt, lt, eq,
    input  max_pix, min_pix, slices
  );
endinterface

// File: rtl/serial_pixel_comparator.sv
// MSB-first 2-bit-slice pixel comparator, early exit.
// Ports: clk, rst (sync high), bus (slave modport).
module serial_pixel_comparator #(
  parameter int PIX_W         = 8,
  parameter int APPROX_SLICES = 0
) (
  input  logic clk,
  input  logic rst,
  serial_pixel_comparator_if.slave bus
);
  localparam int SW = $clog2(PIX_W/2) + 1;
  localparam logic [SW-1:0] N =
    SW'(PIX_W/2 - APPROX_SLICES);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t state, state_d;

  logic [PIX_W-1:0] xs_q, ys_q;
  logic [PIX_W-1:0] x_q, y_q;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [1:0]       xs, ys;
  logic             accept;
  logic             hit_gt, hit_lt, hit_eq;

  logic             ov_q, gt_q, lt_q, eq_q;
  logic [PIX_W-1:0] max_q, min_q;
  logic [SW-1:0]    sl_q;

  assign xs = xs_q[PIX_W-1 -: 2];
  assign ys = ys_q[PIX_W-1 -: 2];
  assign cnt_d = cnt_q + SW'(1);

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = ov_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.eq        = eq_q;
  assign bus.max_pix   = max_q;
  assign bus.min_pix   = min_q;
  assign bus.slices    = sl_q;

  always_comb begin
    state_d = state;
    hit_gt  = 1'b0;
    hit_lt  = 1'b0;
    hit_eq  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_d = COMPARE;
      end
      COMPARE: begin
        unique case (1'b1)
          (xs > ys): begin
            hit_gt  = 1'b1;
            state_d = DONE;
          end
          (xs < ys): begin
            hit_lt  = 1'b1;
            state_d = DONE;
          end
          default: begin
            // Equal slice: finish only on the last considered one.
            if (cnt_d == N) begin
              hit_eq  = 1'b1;
              state_d = DONE;
            end
          end
        endcase
      end
      DONE: begin
        if (ov_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      xs_q  <= '0;
      ys_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
      max_q <= '0;
      min_q <= '0;
      sl_q  <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        xs_q  <= bus.x_pix;
        ys_q  <= bus.y_pix;
        x_q   <= bus.x_pix;
        y_q   <= bus.y_pix;
        cnt_q <= '0;
      end
      if (state == COMPARE) begin
        cnt_q <= cnt_d;
        xs_q  <= xs_q << 2;
        ys_q  <= ys_q << 2;
      end
      if (hit_gt) begin
        ov_q  <= 1'b1;
        gt_q  <= 1'b1;
        lt_q  <= 1'b0;
        eq_q  <= 1'b0;
        max_q <= x_q;
        min_q <= y_q;
        sl_q  <= cnt_d;
      end
      if (hit_lt) begin
        ov_q  <= 1'b1;
        gt_q  <= 1'b0;
        lt_q  <= 1'b1;
        eq_q  <= 1'b0;
        max_q <= y_q;
        min_q <= x_q;
        sl_q  <= cnt_d;
      end
      if (hit_eq) begin
        ov_q  <= 1'b1;
        gt_q  <= 1'b0;
        lt_q  <= 1'b0;
        eq_q  <= 1'b1;
        max_q <= x_q;
        min_q <= y_q;
        sl_q  <= N;
      end
      if (state == DONE && ov_q && bus.out_ready)
        ov_q <= 1'b0;
    end
  end
endmodule

// File: doc/serial_pixel_comparator.md
Name: serial_pixel_comparator

Overview:
Sequential pixel comparator that resolves the full PIX_W-bit relation between two pixels. It evaluates one 2-bit slice per cycle, MSB slice first, and terminates early on the first unequal slice. It is the multi-bit consumer of the 2-bit H/L slice encoding. It also provides an approximate mode that ignores low-order slices. It sits between the pixel fetch stage and the sort/median network, using valid/ready handshakes on both sides.

Parameters:
PIX_W, 8, pixel width in bits; must be even and >= 2
APPROX_SLICES, 0, number of LSB 2-bit slices ignored; legal range 0 .. PIX_W/2-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  x_pix/y_pix valid
in_ready  output  1  block can accept a pair
x_pix  input  PIX_W  pixel X
y_pix  input  PIX_W  pixel Y
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
gt  output  1  X > Y (on considered slices)
lt  output  1  X < Y (on considered slices)
eq  output  1  considered slices all equal
max_pix  output  PIX_W  larger pixel; x_pix on eq
min_pix  output  PIX_W  smaller pixel; y_pix on eq
slices  output  clog2(PIX_W/2)+1  number of slices evaluated, 1..PIX_W/2-APPROX_SLICES

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; out_valid, gt, lt, eq=0; max_pix, min_pix, slices=0; internal shift registers cleared. in_ready=0 while rst is high. Reset overrides any in-flight compare or pending result; the pending result is discarded.
- Define N = PIX_W/2 - APPROX_SLICES as the number of considered slices.
- in_ready = (state==IDLE) && !rst. out_valid is registered.
- IDLE:
  - On in_valid && in_ready, capture x_pix and y_pix into working shift registers and into hold registers, clear the slice counter, and go to COMPARE.
  - in_valid without in_ready has no effect; the upstream must hold its data.
- COMPARE: each cycle take the top 2 bits of each shift register (xs, ys) and increment the slice counter.
  - Slice comparison: H = (xs > ys) and L = (xs < ys), unsigned 2-bit values.
  - H=1: register gt=1, lt=0, eq=0, max_pix=X, min_pix=Y, slices=count; go to DONE.
  - L=1: register lt=1, gt=0, eq=0, max_pix=Y, min_pix=X, slices=count; go to DONE.
  - Equal slice and count==N: register eq=1, gt=0, lt=0, max_pix=X, min_pix=Y, slices=N; go to DONE.
  - Equal slice and count<N: shift both registers left by 2 and stay in COMPARE.
- DONE:
  - out_valid=1. Outputs are held stable until out_valid && out_ready.
  - On the handshake, out_valid drops on the next cycle and state goes to IDLE.
  - No new pair is accepted in the same cycle as the result handshake.
- Latency: handshake at cycle T, resolution at slice k means out_valid=1 from cycle T+k+1. Worst case is N+1 cycles. Minimum throughput is 1 pair per k+2 cycles.
- Exactly one of gt, lt, eq is high whenever out_valid=1.
- gt, lt, eq, max_pix, min_pix and slices keep their last values after the handshake until the next result is registered.
- APPROX_SLICES=0 gives an exact comparison. With APPROX_SLICES>0, pixels differing only in the ignored LSB slices report eq.
- Inputs are sampled only at the accept handshake; changes to x_pix/y_pix afterwards are ignored.

Test Plan:
- PIX_W=8, APPROX_SLICES=0: x=0xB4, y=0x3C, out_ready=1 -> out_valid 2 cycles after accept; gt=1, slices=1, max=0xB4, min=0x3C.
- x=0x5A, y=0x5B -> lt=1, slices=4, max=0x5B, min=0x5A; out_valid 5 cycles after accept.
- x=y=0x77 -> eq=1, slices=4, max=min=0x77; then x=0x00, y=0xFF back-to-back -> lt=1, slices=1, and in_ready is low throughout DONE.
- APPROX_SLICES=1: x=0x5A, y=0x5B -> eq=1, slices=3, max=0x5A, min=0x5B. Then x=0x58, y=0x5C -> lt=1, slices=3.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid and all result outputs stay stable, in_ready=0. Raise out_ready for 1 cycle -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-operation: accept x=0x5A, y=0x5B and assert rst during slice 2 -> next cycle out_valid=0, all outputs 0, in_ready=0 while rst is high and 1 after release; a new pair then compares correctly.
